// File: rtl/smc_mac_fsm_lite8.sv
// smc_mac_fsm_lite8: static memory access engine running 1/2/4 byte-wide external accesses per AHB transfer.
// Optional TURN cycle between accesses when SMC_TURNAROUND_EN is defined.
module smc_mac_fsm_lite8 #(
    parameter int WAIT_RD = 2,
    parameter int WAIT_WR = 2
) (
    input  logic        hclk8,
    input  logic        n_sys_reset8,
    input  logic        new_access8,
    input  logic [31:0] addr8,
    input  logic [1:0]  xfer_size8,
    input  logic        n_read8,
    input  logic        cs8,
    input  logic [31:0] write_data8,
    input  logic [7:0]  ext_data_in8,
    output logic        smc_idle8,
    output logic        smc_done8,
    output logic        mac_done8,
    output logic [31:0] read_data8,
    output logic [31:0] ext_addr8,
    output logic [7:0]  ext_data_out8,
    output logic        ext_data_oe8,
    output logic        ext_n_cs8,
    output logic        ext_n_oe8,
    output logic        ext_n_we8
);
`ifdef SMC_TURNAROUND_EN
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;
    localparam state_t GAP = TURN;
`else
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    localparam state_t GAP = SETUP;
`endif
    state_t      state, nxt;
    logic [3:0]  cnt;
    logic [1:0]  k, last, lane;
    logic [31:0] addr_r, wdata_r, wd;
    logic        rd_r, last_byte, acc, busy;

    assign last_byte = k == last;
    assign acc = new_access8 & cs8 & (state == IDLE || (state == HOLD && last_byte));
    assign lane = addr_r[1:0] + k;
    assign busy = state == SETUP || state == STROBE || state == HOLD;
    // the first SETUP of a write is the AHB data phase, so forward the bus directly
    assign wd = (state == SETUP && k == 2'd0) ? write_data8 : wdata_r;

    assign smc_idle8     = state == IDLE;
    assign smc_done8     = state == HOLD;
    assign mac_done8     = state == HOLD && last_byte;
    assign ext_addr8     = {addr_r[31:2], lane};
    assign ext_data_out8 = wd[{lane, 3'b000} +: 8];
    assign ext_data_oe8  = busy & ~rd_r;
    assign ext_n_cs8     = ~busy;
    assign ext_n_oe8     = ~(state == STROBE && rd_r);
    assign ext_n_we8     = ~(state == STROBE && !rd_r);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = acc ? SETUP : IDLE;
            SETUP:   nxt = STROBE;
            STROBE:  nxt = (cnt == 4'd0) ? HOLD : STROBE;
            HOLD:    nxt = (!last_byte || acc) ? GAP : IDLE;
`ifdef SMC_TURNAROUND_EN
            TURN:    nxt = SETUP;
`endif
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge hclk8 or negedge n_sys_reset8) begin
        if (!n_sys_reset8) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            k          <= 2'd0;
            last       <= 2'd0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            rd_r       <= 1'b0;
            read_data8 <= 32'd0;
        end else begin
            state <= nxt;
            if (acc) begin
                addr_r <= addr8;
                rd_r   <= ~n_read8;
                last   <= (xfer_size8 == 2'd0) ? 2'd0 : (xfer_size8 == 2'd1) ? 2'd1 : 2'd3;
                k      <= 2'd0;
                if (!n_read8)
                    read_data8 <= 32'd0;
            end else if (state == HOLD && !last_byte) begin
                k <= k + 2'd1;
            end
            // counter runs WAIT-1 down to 0, so STROBE lasts exactly WAIT cycles
            if (state == SETUP)
                cnt <= rd_r ? 4'(WAIT_RD - 1) : 4'(WAIT_WR - 1);
            else if (state == STROBE)
                cnt <= cnt - 4'd1;
            if (state == SETUP && k == 2'd0 && !rd_r)
                wdata_r <= write_data8;
            if (state == STROBE && cnt == 4'd0 && rd_r)
                read_data8[{lane, 3'b000} +: 8] <= ext_data_in8;
        end
    end
endmodule

// File: tb/tb_smc_mac_fsm_lite8.sv
// tb_smc_mac_fsm_lite8: randomized scoreboard bench; driver queues expected byte accesses,
// monitor checks each HOLD cycle against them.
module tb_smc_mac_fsm_lite8;
    localparam int RD = 3;
    localparam int WR = 2;
`ifdef SMC_TURNAROUND_EN
    localparam int TA = 1;
`else
    localparam int TA = 0;
`endif

    logic        hclk8, n_sys_reset8, new_access8, n_read8, cs8;
    logic [31:0] addr8, write_data8;
    logic [1:0]  xfer_size8;
    logic [7:0]  ext_data_in8;
    logic        smc_idle8, smc_done8, mac_done8, ext_data_oe8, ext_n_cs8, ext_n_oe8, ext_n_we8;
    logic [31:0] read_data8, ext_addr8;
    logic [7:0]  ext_data_out8;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [7:0]  wb;
        logic        last;
        logic [31:0] rdata;
        int          lat;
        int          t0;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mem[256];
    int         n_cmp = 0, n_bad = 0, cyc = 0, rdc = 0, wrc = 0;

    smc_mac_fsm_lite8 #(.WAIT_RD(RD), .WAIT_WR(WR)) dut (
        .hclk8(hclk8), .n_sys_reset8(n_sys_reset8), .new_access8(new_access8), .addr8(addr8),
        .xfer_size8(xfer_size8), .n_read8(n_read8), .cs8(cs8), .write_data8(write_data8),
        .ext_data_in8(ext_data_in8), .smc_idle8(smc_idle8), .smc_done8(smc_done8),
        .mac_done8(mac_done8), .read_data8(read_data8), .ext_addr8(ext_addr8),
        .ext_data_out8(ext_data_out8), .ext_data_oe8(ext_data_oe8), .ext_n_cs8(ext_n_cs8),
        .ext_n_oe8(ext_n_oe8), .ext_n_we8(ext_n_we8)
    );

    assign ext_data_in8 = mem[ext_addr8[7:0]];

    initial hclk8 = 1'b0;
    always #5 hclk8 = ~hclk8;
    always @(posedge hclk8) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge hclk8) begin
        if (!n_sys_reset8) begin
            rdc = 0;
            wrc = 0;
        end else begin
            if (!ext_n_oe8) rdc++;
            if (!ext_n_we8) wrc++;
            if (mac_done8 && !smc_done8) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mac_done_outside_hold: got 1 expected 0");
            end
            if (smc_done8) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_hold: got HOLD with empty scoreboard expected none");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ext_addr", ext_addr8, e.addr);
                    chk("oe_cycles", rdc, e.rd ? RD : 0);
                    chk("we_cycles", wrc, e.rd ? 0 : WR);
                    chk("data_oe", {31'd0, ext_data_oe8}, {31'd0, ~e.rd});
                    chk("n_cs_hold", {31'd0, ext_n_cs8}, 32'd0);
                    if (!e.rd) chk("write_byte", {24'd0, ext_data_out8}, {24'd0, e.wb});
                    chk("mac_done", {31'd0, mac_done8}, {31'd0, e.last});
                    if (e.last) chk("latency", cyc - e.t0, e.lat);
                    if (e.last && e.rd) chk("read_data", read_data8, e.rdata);
                end
                rdc = 0;
                wrc = 0;
            end
        end
    end

    task automatic wait_ready(output bit b2b);
        int n = 0;
        while (!(smc_idle8 || (smc_done8 && mac_done8)) && n < 300) begin
            new_access8 = 1'($urandom);
            cs8 = 1'b1;
            addr8 = $urandom;
            xfer_size8 = 2'($urandom);
            n_read8 = 1'($urandom);
            @(posedge hclk8);
            #1;
            n++;
        end
        new_access8 = 1'b0;
        if (n >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_ready: got timeout after %0d cycles expected ready", n);
        end
        b2b = !smc_idle8;
    endtask

    task automatic issue(input bit rd, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input bit b2b);
        int n, w;
        logic [31:0] rdat;
        logic [1:0] ln;
        exp_t e;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        w = rd ? RD : WR;
        rdat = 32'd0;
        for (int i = 0; i < n; i++) begin
            ln = a[1:0] + 2'(i);
            if (rd) rdat[8*ln +: 8] = mem[{a[7:2], ln}];
        end
        for (int i = 0; i < n; i++) begin
            ln = a[1:0] + 2'(i);
            e.addr = {a[31:2], ln};
            e.rd = rd;
            e.wb = wd[8*ln +: 8];
            e.last = (i == n - 1);
            e.rdata = rdat;
            e.lat = n * (2 + w + TA) - (b2b ? 0 : TA);
            e.t0 = cyc;
            q.push_back(e);
        end
        new_access8 = 1'b1;
        cs8 = 1'b1;
        addr8 = a;
        xfer_size8 = sz;
        n_read8 = ~rd;
        @(posedge hclk8);
        #1;
        new_access8 = 1'b0;
        cs8 = 1'($urandom);
        addr8 = $urandom;
        write_data8 = wd;
    endtask

    task automatic rand_xfer(input bit b2b);
        logic [1:0] sz;
        logic [31:0] a;
        sz = 2'($urandom);
        a = $urandom;
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz[1]) a[1:0] = 2'd0;
        issue(1'($urandom), sz, a, $urandom, b2b);
    endtask

    initial begin
        bit b2b;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[2] = 8'hA5;
        mem[6] = 8'h5A;
        mem[7] = 8'hC3;
        n_sys_reset8 = 1'b1;
        new_access8 = 1'b0;
        cs8 = 1'b0;
        addr8 = 32'd0;
        xfer_size8 = 2'd0;
        n_read8 = 1'b0;
        write_data8 = 32'd0;
        #2 n_sys_reset8 = 1'b0;
        #1;
        chk("rst_idle", {31'd0, smc_idle8}, 32'd1);
        chk("rst_done", {30'd0, smc_done8, mac_done8}, 32'd0);
        chk("rst_read_data", read_data8, 32'd0);
        chk("rst_ext_addr", ext_addr8, 32'd0);
        chk("rst_strobes", {28'd0, ext_data_oe8, ext_n_cs8, ext_n_oe8, ext_n_we8}, 32'h7);
        chk("rst_data_out", {24'd0, ext_data_out8}, 32'd0);
        repeat (2) @(posedge hclk8);
        #2 n_sys_reset8 = 1'b1;
        @(posedge hclk8);
        #1;

        wait_ready(b2b); issue(1'b1, 2'd0, 32'h0000_0002, 32'd0, b2b);
        wait_ready(b2b); issue(1'b0, 2'd2, 32'h0000_0100, 32'h1122_3344, b2b);
        wait_ready(b2b); issue(1'b1, 2'd1, 32'h0000_0006, 32'd0, b2b);
        wait_ready(b2b); issue(1'b1, 2'd2, 32'h0000_0044, 32'd0, b2b);
        wait_ready(b2b); issue(1'b0, 2'd0, 32'h0000_0013, 32'hDEAD_BEEF, b2b);

        for (int t = 0; t < 60; t++) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                new_access8 = 1'($urandom);
                cs8 = 1'b0;
                @(posedge hclk8);
                #1;
            end
            new_access8 = 1'b0;
            wait_ready(b2b);
            rand_xfer(b2b);
        end

        wait_ready(b2b);
        issue(1'b0, 2'd2, 32'h0000_0200, 32'hCAFE_F00D, b2b);
        n = 0;
        while (ext_n_we8 && n < 50) begin
            @(posedge hclk8);
            #1;
            n++;
        end
        chk("reach_strobe", {31'd0, ext_n_we8}, 32'd0);
        n_sys_reset8 = 1'b0;
        #1;
        q.delete();
        chk("abort_idle", {31'd0, smc_idle8}, 32'd1);
        chk("abort_strobes", {28'd0, ext_data_oe8, ext_n_cs8, ext_n_oe8, ext_n_we8}, 32'h7);
        chk("abort_done", {30'd0, smc_done8, mac_done8}, 32'd0);
        @(negedge hclk8);
        #2 n_sys_reset8 = 1'b1;
        @(posedge hclk8);
        #1;
        wait_ready(b2b); issue(1'b1, 2'd2, 32'h0000_0020, 32'd0, b2b);
        wait_ready(b2b); rand_xfer(b2b);

        n = 0;
        while ((q.size() != 0 || !smc_idle8) && n < 300) begin
            @(posedge hclk8);
            #1;
            n++;
        end
        chk("drain", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
